preload_sequencer: RTL and testbench
====================================

PRELOAD_SEQUENCER -- requirements
Module: preload_sequencer

Interface
REQ-001 SHALL have parameter RUN_LIMIT, default 1024: core cycles allowed in RUN before forced stop (1..65535).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- start  in  1  begin load session
- halt  in  1  stop a running program
- in_valid  in  1  record offered
- in_ready  out  1  record accepted when in_valid is also high
- in_type  in  2  00 instr, 01 reg, 10 LS, 11 END
- in_addr  in  15  target address
- in_data  in  128  payload; bit 0 is MSB
- load_en  out  1  instruction memory write
- instruction_in  out  32  instruction word
- instr_load_addr  out  10  instruction address
- preload_en  out  1  register file write
- preload_addr  out  10  register address
- preload_values  out  128  register data
- preload_LS_en  out  1  local store write
- preload_LS_addr  out  15  local store address
- preload_LS_data  out  128  local store data
- core_rst  out  1  reset to core; high holds core idle
- busy  out  1  session in progress
- done  out  1  run finished normally
- err  out  1  session aborted
- loaded_cnt  out  16  records written, saturating at 65535

Function
REQ-003 SHALL implement states IDLE, LOAD, DRAIN, RUN, DONE, ERROR.
REQ-004 IDLE: in_ready=0, core_rst=1; start=1 -> LOAD, loaded_cnt cleared.
REQ-005 LOAD: in_ready=1 every cycle, so back-to-back accepts are allowed.
REQ-006 An accepted record SHALL drive exactly one write enable for exactly one cycle, on the cycle after acceptance (1-cycle latency).
REQ-007 Type 00: instruction_in=in_data[0:31], instr_load_addr=in_addr[5:14]; in_addr[0:4] nonzero -> ERROR, no write.
REQ-008 Type 01: preload_addr=in_addr[5:14], preload_values=in_data; in_addr>127 -> ERROR, no write.
REQ-009 Type 10: preload_LS_addr=in_addr, preload_LS_data=in_data; all addresses legal.
REQ-010 loaded_cnt SHALL increment by 1 per performed write and SHALL saturate at 65535.
REQ-011 Type 11 (END) SHALL produce no write and SHALL move to DRAIN; in_ready=0 from the next cycle.
REQ-012 DRAIN SHALL last one cycle so the final write completes, then go to RUN.
REQ-013 RUN: core_rst=0; a cycle counter SHALL start at 0 and increment each RUN cycle.
REQ-014 RUN SHALL go to DONE when halt=1 or when the counter reaches RUN_LIMIT-1; if both occur in the same cycle, DONE.
REQ-015 DONE: core_rst=1, done=1; start=1 -> LOAD (new session, done cleared).
REQ-016 ERROR: core_rst=1, err=1, in_ready=0; SHALL be left only by rst.
REQ-017 start SHALL be ignored in LOAD, DRAIN, RUN and ERROR; halt SHALL be ignored outside RUN.
REQ-018 busy SHALL be 1 in LOAD, DRAIN and RUN, and 0 otherwise.
REQ-019 Data and address outputs SHALL hold their last value when their enable is 0.

Reset
REQ-020 rst=1 SHALL force IDLE, all enables 0, in_ready=0, core_rst=1, busy=done=err=0, loaded_cnt=0, all data/address outputs 0.
REQ-021 rst in any state, including mid-LOAD and RUN, SHALL take effect on the next edge; a write pending from an acceptance in the same cycle SHALL be dropped.

Configuration
REQ-022 Macro PRELOAD_CHECKSUM_EN defined: maintain a 128-bit XOR of in_data over all accepted type 00/01/10 records, cleared on entry to LOAD; an END record whose in_data differs from it -> ERROR instead of DRAIN.
REQ-023 PRELOAD_CHECKSUM_EN undefined: no checksum register; END in_data ignored.

Verification
REQ-024 rst; start; records {00,addr 5,data[0:31]=0x12345678},{01,addr 3,data=all-ones},{10,addr 0x7FFF,data=0xA5..A5},END on consecutive cycles -> load_en, preload_en, preload_LS_en each high for one cycle at accept+1 with matching addr/data; loaded_cnt=3; core_rst falls 2 cycles after END accept.
REQ-025 RUN_LIMIT=4, no halt -> core_rst low exactly 4 cycles, then done=1, busy=0.
REQ-026 Type 01 addr 128 -> no preload_en, err=1, core_rst=1; start ignored; only rst clears it.
REQ-027 rst asserted in the cycle a type 10 record is accepted -> preload_LS_en never asserts; state IDLE, loaded_cnt=0.
REQ-028 With PRELOAD_CHECKSUM_EN: records with data 0x1 and 0x3, END data 0x2 -> RUN; END data 0x3 -> err=1.
REQ-029 halt and counter reaching RUN_LIMIT-1 in the same cycle -> single transition to DONE, done=1, err=0.

Source files
------------

// File: rtl/preload_sequencer.sv
// preload_sequencer: streams instr/reg/local-store records into a core, then runs it for a bounded time; define PRELOAD_CHECKSUM_EN to check an END-record XOR checksum
module preload_sequencer #(
  parameter int RUN_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_type,
  input  logic [14:0]  in_addr,
  input  logic [127:0] in_data,
  output logic         load_en,
  output logic [31:0]  instruction_in,
  output logic [9:0]   instr_load_addr,
  output logic         preload_en,
  output logic [9:0]   preload_addr,
  output logic [127:0] preload_values,
  output logic         preload_LS_en,
  output logic [14:0]  preload_LS_addr,
  output logic [127:0] preload_LS_data,
  output logic         core_rst,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  loaded_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN, S_DONE, S_ERROR} state_t;
  localparam logic [15:0] LIM = 16'(RUN_LIMIT - 1);
  state_t r_state;
  logic r_in_ready, r_core_rst, r_busy, r_done, r_err;
  logic r_load_en, r_pre_en, r_ls_en;
  logic [31:0] r_instr;
  logic [9:0] r_iaddr, r_paddr;
  logic [127:0] r_pval, r_lsdata;
  logic [14:0] r_lsaddr;
  logic [15:0] r_cnt, r_run_cnt, w_cnt_inc;
  logic w_acc, w_bad, w_sum_bad, w_enter, w_wr_i, w_wr_r, w_wr_l, w_wr;
  assign w_acc = r_in_ready & in_valid;
  assign w_enter = start & (r_state == S_IDLE || r_state == S_DONE);
  assign w_bad = (in_type == 2'b00 && in_addr[14:10] != 5'd0) ||
                 (in_type == 2'b01 && in_addr[14:7] != 8'd0) ||
                 (in_type == 2'b11 && w_sum_bad);
  assign w_wr_i = w_acc & ~w_bad & (in_type == 2'b00);
  assign w_wr_r = w_acc & ~w_bad & (in_type == 2'b01);
  assign w_wr_l = w_acc & (in_type == 2'b10);
  assign w_wr = w_wr_i | w_wr_r | w_wr_l;
  assign w_cnt_inc = r_cnt + {15'd0, ~&r_cnt};
`ifdef PRELOAD_CHECKSUM_EN
  logic [127:0] r_sum;
  assign w_sum_bad = r_sum != in_data;
  // running XOR of every accepted payload record, restarted with each session
  always_ff @(posedge clk) begin
    if (rst || w_enter) r_sum <= '0;
    else if (w_acc && in_type != 2'b11) r_sum <= r_sum ^ in_data;
  end
`else
  assign w_sum_bad = 1'b0;
`endif
  // session state machine with its registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_in_ready <= 1'b0;
      r_core_rst <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_run_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state <= S_LOAD;
          r_in_ready <= 1'b1;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_cnt <= '0;
        end
        S_LOAD: begin
          if (w_wr) r_cnt <= w_cnt_inc;
          if (w_acc && w_bad) begin
            r_state <= S_ERROR;
            r_in_ready <= 1'b0;
            r_busy <= 1'b0;
            r_err <= 1'b1;
          end else if (w_acc && in_type == 2'b11) begin
            r_state <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_state <= S_RUN;
          r_core_rst <= 1'b0;
          r_run_cnt <= '0;
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 16'd1;
          if (halt || r_run_cnt == LIM) begin
            r_state <= S_DONE;
            r_core_rst <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  // one-cycle write strobes with fields that hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_en <= 1'b0;
      r_pre_en <= 1'b0;
      r_ls_en <= 1'b0;
      r_instr <= '0;
      r_iaddr <= '0;
      r_paddr <= '0;
      r_pval <= '0;
      r_lsaddr <= '0;
      r_lsdata <= '0;
    end else begin
      r_load_en <= w_wr_i;
      r_pre_en <= w_wr_r;
      r_ls_en <= w_wr_l;
      if (w_wr_i) begin
        r_instr <= in_data[127:96];
        r_iaddr <= in_addr[9:0];
      end
      if (w_wr_r) begin
        r_paddr <= in_addr[9:0];
        r_pval <= in_data;
      end
      if (w_wr_l) begin
        r_lsaddr <= in_addr;
        r_lsdata <= in_data;
      end
    end
  end
  assign in_ready = r_in_ready;
  assign core_rst = r_core_rst;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
  assign loaded_cnt = r_cnt;
  assign load_en = r_load_en;
  assign instruction_in = r_instr;
  assign instr_load_addr = r_iaddr;
  assign preload_en = r_pre_en;
  assign preload_addr = r_paddr;
  assign preload_values = r_pval;
  assign preload_LS_en = r_ls_en;
  assign preload_LS_addr = r_lsaddr;
  assign preload_LS_data = r_lsdata;
endmodule

// File: tb/tb_preload_sequencer.sv
// tb_preload_sequencer: directed sessions checked against a session-level model every cycle
module tb_preload_sequencer;
  localparam int RL = 4;
`ifdef PRELOAD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_RUN = 3, P_DONE = 4, P_ERR = 5;
  logic clk = 1'b0;
  logic rst, start, halt, in_valid, in_ready;
  logic [1:0] in_type;
  logic [14:0] in_addr;
  logic [127:0] in_data;
  logic load_en, preload_en, preload_LS_en, core_rst, busy, done, err;
  logic [31:0] instruction_in;
  logic [9:0] instr_load_addr, preload_addr;
  logic [127:0] preload_values, preload_LS_data;
  logic [14:0] preload_LS_addr;
  logic [15:0] loaded_cnt;
  int n_chk = 0, n_pass = 0;
  bit armed = 1'b0;
  int ph = P_IDLE, age = 0, e_cnt = 0;
  bit e_load_en, e_pre_en, e_ls_en;
  logic [31:0] e_instr;
  logic [9:0] e_iaddr, e_paddr;
  logic [127:0] e_pval, e_lsdata, m_sum;
  logic [14:0] e_lsaddr;

  preload_sequencer #(.RUN_LIMIT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_addr(in_addr), .in_data(in_data), .load_en(load_en),
    .instruction_in(instruction_in), .instr_load_addr(instr_load_addr), .preload_en(preload_en),
    .preload_addr(preload_addr), .preload_values(preload_values), .preload_LS_en(preload_LS_en),
    .preload_LS_addr(preload_LS_addr), .preload_LS_data(preload_LS_data), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err), .loaded_cnt(loaded_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input logic [1:0] t, input logic [14:0] a, input logic [127:0] d);
    in_valid = 1'b1;
    in_type = t;
    in_addr = a;
    in_data = d;
  endtask

  // session-level model: what each edge must do according to the record rules
  initial forever begin
    @(posedge clk);
    e_load_en = 0;
    e_pre_en = 0;
    e_ls_en = 0;
    if (rst) begin
      ph = P_IDLE;
      e_cnt = 0;
      e_instr = 0;
      e_iaddr = 0;
      e_paddr = 0;
      e_pval = 0;
      e_lsaddr = 0;
      e_lsdata = 0;
      m_sum = 0;
    end else if ((ph == P_IDLE || ph == P_DONE) && start) begin
      ph = P_LOAD;
      e_cnt = 0;
      m_sum = 0;
    end else if (ph == P_LOAD && in_valid) begin
      if (in_type == 2'd3) ph = (CSUM && in_data != m_sum) ? P_ERR : P_DRAIN;
      else begin
        m_sum = m_sum ^ in_data;
        if ((in_type == 2'd0 && in_addr >= 1024) || (in_type == 2'd1 && in_addr > 127)) ph = P_ERR;
        else begin
          if (e_cnt < 65535) e_cnt++;
          if (in_type == 2'd0) begin
            e_load_en = 1;
            e_instr = in_data[127:96];
            e_iaddr = 10'(in_addr % 1024);
          end else if (in_type == 2'd1) begin
            e_pre_en = 1;
            e_paddr = 10'(in_addr);
            e_pval = in_data;
          end else begin
            e_ls_en = 1;
            e_lsaddr = in_addr;
            e_lsdata = in_data;
          end
        end
      end
    end else if (ph == P_DRAIN) begin
      ph = P_RUN;
      age = 0;
    end else if (ph == P_RUN) begin
      if (halt || age == RL - 1) ph = P_DONE;
      age++;
    end
  end

  // every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("in_ready", in_ready, ph == P_LOAD);
      chk("core_rst", core_rst, ph != P_RUN);
      chk("busy", busy, ph == P_LOAD || ph == P_DRAIN || ph == P_RUN);
      chk("done", done, ph == P_DONE);
      chk("err", err, ph == P_ERR);
      chk("loaded_cnt", loaded_cnt, e_cnt);
      chk("load_en", load_en, e_load_en);
      chk("instruction_in", instruction_in, e_instr);
      chk("instr_load_addr", instr_load_addr, e_iaddr);
      chk("preload_en", preload_en, e_pre_en);
      chk("preload_addr", preload_addr, e_paddr);
      chk("preload_values", preload_values, e_pval);
      chk("preload_LS_en", preload_LS_en, e_ls_en);
      chk("preload_LS_addr", preload_LS_addr, e_lsaddr);
      chk("preload_LS_data", preload_LS_data, e_lsdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d0, d1, d2;
    int n;
    d0 = {32'h12345678, 96'h0};
    d1 = '1;
    d2 = {16{8'hA5}};
    rst = 1; start = 0; halt = 0; in_valid = 0; in_type = 0; in_addr = 0; in_data = 0;
    repeat (2) tick();
    armed = 1'b1;
    chk("rst core_rst", core_rst, 1);
    chk("rst busy", busy, 0);
    chk("rst loaded_cnt", loaded_cnt, 0);
    chk("rst in_ready", in_ready, 0);
    rst = 0;
    halt = 1;
    tick();
    halt = 0;
    chk("idle in_ready", in_ready, 0);
    chk("idle halt ignored", busy, 0);
    start = 1;
    tick();
    start = 0;
    chk("load in_ready", in_ready, 1);
    rec(2'd0, 15'd5, d0);
    tick();
    chk("instr load_en", load_en, 1);
    chk("instr word", instruction_in, 32'h12345678);
    chk("instr addr", instr_load_addr, 5);
    rec(2'd1, 15'd3, d1);
    tick();
    chk("reg preload_en", preload_en, 1);
    chk("reg load_en low", load_en, 0);
    chk("reg addr", preload_addr, 3);
    chk("reg data", preload_values, d1);
    rec(2'd2, 15'h7FFF, d2);
    tick();
    chk("ls en", preload_LS_en, 1);
    chk("ls addr", preload_LS_addr, 15'h7FFF);
    chk("ls data", preload_LS_data, d2);
    rec(2'd3, 15'd0, d0 ^ d1 ^ d2);
    tick();
    in_valid = 0;
    chk("drain in_ready", in_ready, 0);
    chk("drain loaded_cnt", loaded_cnt, 3);
    chk("drain core_rst", core_rst, 1);
    tick();
    chk("run core_rst", core_rst, 0);
    n = 0;
    for (int i = 0; i < 20 && core_rst === 1'b0; i++) begin
      n++;
      start = (i == 1);
      tick();
    end
    start = 0;
    chk("run length", n, RL);
    chk("finish done", done, 1);
    chk("finish busy", busy, 0);
    start = 1;
    tick();
    chk("restart done cleared", done, 0);
    rec(2'd0, 15'd1023, 128'hCAFE);
    tick();
    start = 0;
    rec(2'd3, 15'd0, 128'hCAFE);
    tick();
    in_valid = 0;
    tick();
    tick();
    halt = 1;
    tick();
    halt = 0;
    chk("early halt done", done, 1);
    start = 1;
    tick();
    start = 0;
    rec(2'd3, 15'd0, 128'h0);
    tick();
    in_valid = 0;
    tick();
    repeat (3) tick();
    halt = 1;
    tick();
    halt = 0;
    chk("halt+limit done", done, 1);
    chk("halt+limit err", err, 0);
    tick();
    chk("halt+limit stays done", done, 1);
    start = 1;
    tick();
    start = 0;
    rec(2'd1, 15'd128, d1);
    tick();
    in_valid = 0;
    chk("bad reg err", err, 1);
    chk("bad reg no write", preload_en, 0);
    chk("bad reg core_rst", core_rst, 1);
    start = 1;
    repeat (2) tick();
    start = 0;
    chk("err sticky", err, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("err cleared", err, 0);
    start = 1;
    tick();
    start = 0;
    rec(2'd0, 15'h0400, d0);
    tick();
    in_valid = 0;
    chk("bad instr err", err, 1);
    chk("bad instr no write", load_en, 0);
    rst = 1;
    tick();
    rst = 0;
    start = 1;
    tick();
    start = 0;
    rec(2'd2, 15'd100, d2);
    rst = 1;
    tick();
    rst = 0;
    in_valid = 0;
    chk("rst drops ls write", preload_LS_en, 0);
    chk("rst drops count", loaded_cnt, 0);
    tick();
    chk("rst idle ready", in_ready, 0);
    start = 1;
    tick();
    start = 0;
    rec(2'd2, 15'd1, 128'h1);
    tick();
    rec(2'd2, 15'd2, 128'h3);
    tick();
    rec(2'd3, 15'd0, 128'h2);
    tick();
    in_valid = 0;
    tick();
    chk("good sum runs", core_rst, 0);
    repeat (6) tick();
    start = 1;
    tick();
    start = 0;
    rec(2'd2, 15'd1, 128'h1);
    tick();
    rec(2'd2, 15'd2, 128'h3);
    tick();
    rec(2'd3, 15'd0, 128'h3);
    tick();
    in_valid = 0;
    chk("bad sum err", err, CSUM);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
